masked_mem_req_arbiter: RTL and testbench

MASKED_MEM_REQ_ARBITER -- requirements
Module: masked_mem_req_arbiter

---
 rtl/masked_mem_pkg.sv | 27 ++
 rtl/masked_mem_order_fifo.sv | 53 +++++
 rtl/masked_mem_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_masked_mem_req_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_mem_pkg.sv
// Shared types for the masked memory request arbiter.
// Holds FSM encodings and message-length geometry.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH_HI
`define MSG_LENGTH_HI 29
`endif
`ifndef MSG_LENGTH_LO
`define MSG_LENGTH_LO 22
`endif

package masked_mem_pkg;

  localparam int MSG_LEN_W = `MSG_LENGTH_HI - `MSG_LENGTH_LO + 1;

  typedef enum logic {
    REQ_IDLE,
    REQ_BODY
  } req_state_e;

  typedef enum logic {
    RESP_IDLE,
    RESP_BODY
  } resp_state_e;

endpackage

// File: rtl/masked_mem_order_fifo.sv
// Order FIFO: remembers which source owns each outstanding request.
// Simultaneous push and pop are allowed, including while full.
module masked_mem_order_fifo
  import masked_mem_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   num_els_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign num_els_o = cnt_q;
  assign data_o    = mem_q[rd_q];
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok   = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      if (push_ok && !pop_ok) cnt_q <= cnt_q + 1'b1;
      if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/masked_mem_req_arbiter.sv
// Round-robin merge of per-source message streams to one controller,
// with in-order routing of responses back to their source.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_LENGTH_HI
`define MSG_LENGTH_HI 29
`endif
`ifndef MSG_LENGTH_LO
`define MSG_LENGTH_LO 22
`endif

module masked_mem_req_arbiter
  import masked_mem_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int NOC_DATA_W  = `NOC_DATA_WIDTH,
  parameter int MSG_LEN_HI  = `MSG_LENGTH_HI,
  parameter int MSG_LEN_LO  = `MSG_LENGTH_LO,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_arb_val,
  input  logic [NUM_SRC*NOC_DATA_W-1:0] src_arb_data,
  output logic [NUM_SRC-1:0]            arb_src_rdy,
  output logic                          arb_ctrl_val,
  output logic [NOC_DATA_W-1:0]         arb_ctrl_data,
  input  logic                          ctrl_arb_rdy,
  input  logic                          ctrl_arb_resp_val,
  input  logic [NOC_DATA_W-1:0]         ctrl_arb_resp_data,
  output logic                          arb_ctrl_resp_rdy,
  output logic [NUM_SRC-1:0]            arb_dst_resp_val,
  output logic [NOC_DATA_W-1:0]         arb_dst_resp_data,
  input  logic [NUM_SRC-1:0]            dst_arb_resp_rdy,
  output logic [$clog2(ORDER_DEPTH):0]  arb_outstanding
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int LW = MSG_LEN_HI - MSG_LEN_LO + 1;

  req_state_e  req_q, req_d;
  resp_state_e resp_q, resp_d;

  logic [SW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] rcnt_q, rcnt_d;

  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic [SW-1:0] g;
  logic          found;
  logic          active;
  logic          xfer;
  logic [LW-1:0] hlen;

  logic [SW-1:0] head;
  logic          head_ok;
  logic          rxfer;
  logic [LW-1:0] rlen;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  masked_mem_order_fifo #(
    .WIDTH (SW),
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .data_i    (g),
    .pop_i     (pop),
    .data_o    (head),
    .full_o    (full),
    .empty_o   (empty),
    .num_els_o (arb_outstanding)
  );

  always_comb begin
    pick  = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = SW'((int'(rr_q) + i) % NUM_SRC);
      if (!found && src_arb_val[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign arb_dst_resp_data = ctrl_arb_resp_data;
  assign rlen = ctrl_arb_resp_data[MSG_LEN_HI:MSG_LEN_LO];

  always_comb begin
    resp_d            = resp_q;
    rcnt_d            = rcnt_q;
    pop               = 1'b0;
    arb_dst_resp_val  = '0;
    arb_ctrl_resp_rdy = 1'b0;
    head_ok           = rst_n && !empty;
    if (head_ok) begin
      arb_dst_resp_val[head] = ctrl_arb_resp_val;
      arb_ctrl_resp_rdy      = dst_arb_resp_rdy[head];
    end
    rxfer = head_ok && ctrl_arb_resp_val
         && dst_arb_resp_rdy[head];
    if (rxfer) begin
      unique case (resp_q)
        RESP_IDLE: begin
          rcnt_d = rlen;
          if (rlen == '0) pop = 1'b1;
          else            resp_d = RESP_BODY;
        end
        RESP_BODY: begin
          rcnt_d = rcnt_q - 1'b1;
          if (rcnt_q == LW'(1)) begin
            pop    = 1'b1;
            resp_d = RESP_IDLE;
          end
        end
      endcase
    end
  end

  // A pop that frees a full FIFO lets a new header in the same cycle.
  always_comb begin
    req_d        = req_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    push         = 1'b0;
    g            = gnt_q;
    active       = 1'b0;
    arb_ctrl_val = 1'b0;
    arb_src_rdy  = '0;
    unique case (req_q)
      REQ_IDLE: begin
        g      = pick;
        active = found && (!full || pop);
      end
      REQ_BODY: begin
        g      = gnt_q;
        active = 1'b1;
      end
    endcase
    if (!rst_n) active = 1'b0;
    arb_ctrl_data = src_arb_data[g*NOC_DATA_W +: NOC_DATA_W];
    hlen = arb_ctrl_data[MSG_LEN_HI:MSG_LEN_LO];
    if (active) begin
      arb_ctrl_val   = src_arb_val[g];
      arb_src_rdy[g] = ctrl_arb_rdy;
    end
    xfer = active && src_arb_val[g] && ctrl_arb_rdy;
    if (xfer) begin
      unique case (req_q)
        REQ_IDLE: begin
          push  = 1'b1;
          gnt_d = g;
          cnt_d = hlen;
          if (hlen == '0) rr_d  = g;
          else            req_d = REQ_BODY;
        end
        REQ_BODY: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LW'(1)) begin
            req_d = REQ_IDLE;
            rr_d  = g;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= REQ_IDLE;
      resp_q <= RESP_IDLE;
      gnt_q  <= '0;
      rr_q   <= SW'(NUM_SRC - 1);
      cnt_q  <= '0;
      rcnt_q <= '0;
    end else begin
      req_q  <= req_d;
      resp_q <= resp_d;
      gnt_q  <= gnt_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
      rcnt_q <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_masked_mem_req_arbiter.sv
// Bench for masked_mem_req_arbiter: source/controller models,
// flit scoreboards, a message vector table and corner sequences.
module tb_masked_mem_req_arbiter;

  localparam int NS    = 4;
  localparam int W     = 16;
  localparam int HI    = 11;
  localparam int LO    = 8;
  localparam int DEPTH = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  typedef struct {
    int src;
    int len;
    int rlen;
    int cycles;
  } vec_t;

  typedef struct {
    int          dst;
    logic [W-1:0] data;
  } rexp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_arb_val;
  logic [NS*W-1:0] src_arb_data;
  logic [NS-1:0]   arb_src_rdy;
  logic            arb_ctrl_val;
  logic [W-1:0]    arb_ctrl_data;
  logic            ctrl_arb_rdy;
  logic            ctrl_arb_resp_val;
  logic [W-1:0]    ctrl_arb_resp_data;
  logic            arb_ctrl_resp_rdy;
  logic [NS-1:0]   arb_dst_resp_val;
  logic [W-1:0]    arb_dst_resp_data;
  logic [NS-1:0]   dst_arb_resp_rdy;
  logic [OW-1:0]   arb_outstanding;

  logic [W-1:0]  sq [NS][$];
  logic [W-1:0]  exp_req [$];
  logic [W-1:0]  cq [$];
  rexp_t         exp_resp [$];
  bit            cx_h [$];
  bit            rx_h [$];
  bit            cv_h [$];
  logic [NS-1:0] srdy_h [$];
  logic [NS-1:0] dval_h [$];
  logic [NS-1:0] dst_rdy;

  int nerr = 0;
  int nchk = 0;
  int tag  = 0;

  always #5 clk = ~clk;

  masked_mem_req_arbiter #(
    .NUM_SRC     (NS),
    .NOC_DATA_W  (W),
    .MSG_LEN_HI  (HI),
    .MSG_LEN_LO  (LO),
    .ORDER_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .src_arb_val        (src_arb_val),
    .src_arb_data       (src_arb_data),
    .arb_src_rdy        (arb_src_rdy),
    .arb_ctrl_val       (arb_ctrl_val),
    .arb_ctrl_data      (arb_ctrl_data),
    .ctrl_arb_rdy       (ctrl_arb_rdy),
    .ctrl_arb_resp_val  (ctrl_arb_resp_val),
    .ctrl_arb_resp_data (ctrl_arb_resp_data),
    .arb_ctrl_resp_rdy  (arb_ctrl_resp_rdy),
    .arb_dst_resp_val   (arb_dst_resp_val),
    .arb_dst_resp_data  (arb_dst_resp_data),
    .dst_arb_resp_rdy   (dst_arb_resp_rdy),
    .arb_outstanding    (arb_outstanding)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: got an event, expected none", nm);
  endtask

  task automatic send(input int s, input int n);
    logic [W-1:0] f;
    f = {4'(s), 4'(n), 8'(tag)};
    tag++;
    sq[s].push_back(f);
    exp_req.push_back(f);
    for (int k = 0; k < n; k++) begin
      f = {4'(s), 4'hF, 8'(tag)};
      tag++;
      sq[s].push_back(f);
      exp_req.push_back(f);
    end
  endtask

  task automatic resp(input int d, input int n);
    rexp_t r;
    r.dst  = d;
    r.data = {4'(d), 4'(n), 8'(tag)};
    tag++;
    cq.push_back(r.data);
    exp_resp.push_back(r);
    for (int k = 0; k < n; k++) begin
      r.data = {4'(d), 4'hF, 8'(tag)};
      tag++;
      cq.push_back(r.data);
      exp_resp.push_back(r);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      src_arb_val[i] = (sq[i].size() != 0);
      if (sq[i].size() != 0) src_arb_data[i*W +: W] = sq[i][0];
      else                   src_arb_data[i*W +: W] = '0;
    end
    ctrl_arb_resp_val = (cq.size() != 0);
    if (cq.size() != 0) ctrl_arb_resp_data = cq[0];
    else                ctrl_arb_resp_data = '0;
    ctrl_arb_rdy     = 1'b1;
    dst_arb_resp_rdy = dst_rdy;
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) sq[i].delete();
    exp_req.delete();
    cq.delete();
    exp_resp.delete();
    drive();
  endtask

  task automatic clear_hist();
    cx_h.delete();
    rx_h.delete();
    cv_h.delete();
    srdy_h.delete();
    dval_h.delete();
  endtask

  task automatic cyc();
    logic [NS-1:0] sx;
    bit            cx;
    bit            rx;
    logic [W-1:0]  e;
    rexp_t         r;
    @(negedge clk);
    sx = src_arb_val & arb_src_rdy;
    cx = arb_ctrl_val && ctrl_arb_rdy;
    rx = ctrl_arb_resp_val && arb_ctrl_resp_rdy;
    if (cx) begin
      chk("src_hs_onehot", $countones(sx), 1);
      if (exp_req.size() == 0) bad("req_unexpected");
      else begin
        e = exp_req.pop_front();
        chk("req_flit", arb_ctrl_data, e);
      end
    end
    if (rx) begin
      if (exp_resp.size() == 0) bad("resp_unexpected");
      else begin
        r = exp_resp.pop_front();
        chk("resp_dst", arb_dst_resp_val, 32'(1) << r.dst);
        chk("resp_data", arb_dst_resp_data, r.data);
      end
    end
    cx_h.push_back(cx);
    rx_h.push_back(rx);
    cv_h.push_back(arb_ctrl_val);
    srdy_h.push_back(arb_src_rdy);
    dval_h.push_back(arb_dst_resp_val);
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (sx[i] && sq[i].size() != 0) void'(sq[i].pop_front());
    if (rx && cq.size() != 0) void'(cq.pop_front());
    drive();
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_req.size() != 0) || (cq.size() != 0)
     || (exp_resp.size() != 0);
    for (int i = 0; i < NS; i++)
      if (sq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int max, output int n);
    n = 0;
    while (pending() && n < max) begin
      cyc();
      n++;
    end
    if (pending()) begin
      bad("drain_timeout");
      flush();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    int   n;
    tbl[0] = '{src: 0, len: 2,  rlen: 1,  cycles: 3};
    tbl[1] = '{src: 1, len: 0,  rlen: 0,  cycles: 2};
    tbl[2] = '{src: 2, len: 3,  rlen: 0,  cycles: 4};
    tbl[3] = '{src: 3, len: 0,  rlen: 3,  cycles: 5};
    tbl[4] = '{src: 1, len: 1,  rlen: 1,  cycles: 3};
    tbl[5] = '{src: 2, len: 4,  rlen: 2,  cycles: 5};
    tbl[6] = '{src: 3, len: 15, rlen: 15, cycles: 17};

    rst_n   = 1'b0;
    dst_rdy = '1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl_val", arb_ctrl_val, 0);
    chk("rst_outstanding", arb_outstanding, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_resp_rdy", arb_ctrl_resp_rdy, 0);
    chk("idle_dst_val", arb_dst_resp_val, 0);
    @(posedge clk);
    #1;

    // Two simultaneous 3-flit messages: 0 then 2, no gap
    clear_hist();
    send(0, 2);
    send(2, 2);
    drive();
    drain(20, n);
    chk("r028_cycles", n, 6);
    chk("r028_first_rdy", srdy_h[0], 4'b0001);
    chk("r028_second_rdy", srdy_h[3], 4'b0100);
    chk("r028_outstanding", arb_outstanding, 2);
    resp(0, 1);
    resp(2, 0);
    drive();
    drain(20, n);
    chk("r028_drained", arb_outstanding, 0);

    // One-flit message from 1, next source granted the cycle after
    clear_hist();
    send(1, 0);
    send(2, 0);
    drive();
    drain(20, n);
    chk("r029_cycles", n, 2);
    chk("r029_rdy1", srdy_h[0], 4'b0010);
    chk("r029_rdy2", srdy_h[1], 4'b0100);
    chk("r029_outstanding", arb_outstanding, 2);
    resp(1, 0);
    resp(2, 0);
    drive();
    drain(20, n);
    chk("r029_drained", arb_outstanding, 0);

    // Order FIFO full: third source stalls
    clear_hist();
    send(3, 1);
    send(0, 1);
    send(1, 1);
    drive();
    repeat (6) cyc();
    chk("r030_outstanding", arb_outstanding, 2);
    chk("r030_src1_waiting", sq[1].size(), 2);
    chk("r030_stall_val", cv_h[5], 0);
    chk("r030_stall_rdy", srdy_h[5], 0);

    // Responses 3,0,1 with dst 0 back-pressured
    dst_rdy = 4'b1110;
    resp(3, 1);
    resp(0, 0);
    resp(1, 3);
    clear_hist();
    drive();
    repeat (5) cyc();
    chk("r031_full_hold", cx_h[0], 0);
    chk("r031_push_on_pop", cx_h[1], 1);
    chk("r031_pop_cycle", rx_h[1], 1);
    chk("r031_dst0_val", dval_h[4], 4'b0001);
    chk("r031_stall", rx_h[4], 0);
    chk("r031_stalled_flits", cq.size(), 5);
    dst_rdy = '1;
    drive();
    drain(30, n);
    chk("r031_drained", arb_outstanding, 0);

    for (int t = 0; t < 7; t++) begin
      clear_hist();
      send(tbl[t].src, tbl[t].len);
      resp(tbl[t].src, tbl[t].rlen);
      drive();
      drain(40, n);
      chk($sformatf("vec%0d_cycles", t), n, tbl[t].cycles);
      chk($sformatf("vec%0d_out", t), arb_outstanding, 0);
    end

    // Reset mid-body of a 4-flit message
    clear_hist();
    send(2, 3);
    drive();
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("r032_ctrl_val", arb_ctrl_val, 0);
    chk("r032_src_rdy", arb_src_rdy, 0);
    chk("r032_resp_rdy", arb_ctrl_resp_rdy, 0);
    chk("r032_dst_val", arb_dst_resp_val, 0);
    chk("r032_out", arb_outstanding, 0);
    flush();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("r032_out_after", arb_outstanding, 0);
    clear_hist();
    send(0, 0);
    send(2, 0);
    resp(0, 0);
    resp(2, 0);
    drive();
    drain(20, n);
    chk("r032_first_gnt", srdy_h[0], 4'b0001);
    chk("r032_drained", arb_outstanding, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
